i2c_ctrl: RTL and testbench
===========================

Name: i2c_ctrl

Overview:
- I2C slave bus controller: the sequencer for the i2c_srg shift register in the filter's I2C configuration interface.
- Synchronizes raw SCL/SDA, detects START/STOP and tracks bit/byte framing.
- Drives the shift register's clear and shift strobes, generates ACK and read-data drive on SDA.
- Emits byte-level strobes to the filter register bank.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in each SCL/SDA synchronizer (minimum 2).
- BYTE_CNT_W, 4: width of the data byte counter; saturates at all-ones.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- scl_in  in  1  raw I2C SCL (asynchronous to clk).
- sda_in  in  1  raw I2C SDA (asynchronous to clk).
- sda_out  out  1  SDA open-drain control: 0 = pull low, 1 = release.
- srg_clr_out  out  1  one-cycle clear strobe to i2c_srg clr_in.
- srg_next_out  out  1  one-cycle shift strobe to i2c_srg next_in.
- srg_bit_out  out  1  serial bit to i2c_srg bit_in (synchronized SDA).
- srg_bit_in  in  1  i2c_srg bit_out (MSB, used for read drive).
- srg_addrok_in  in  1  i2c_srg addrok_out (address match).
- rnw_out  out  1  R/W bit of current transaction (1 = read).
- wr_byte_out  out  1  one-cycle pulse: write data byte complete in i2c_srg.
- rd_req_out  out  1  one-cycle pulse: upstream must load next read byte into i2c_srg.
- byte_cnt_out  out  BYTE_CNT_W  data bytes acknowledged since last START.
- busy_out  out  1  1 from addressed START until STOP/NACK end.

Behaviour:
- Synchronizers: SYNC_STAGES flops per line, reset to 1. Edges are detected on the synchronized values against a registered copy (scl_rise, scl_fall, sda_rise, sda_fall).
- Timing requirement: SCL high and low phases ≥ 4 clk cycles.
- START: sda_fall while SCL high. STOP: sda_rise while SCL high. Both are valid in any state, and a STOP/START takes priority over the data edge in the same cycle.
- srg_bit_out = synchronized SDA, combinationally.
- States: IDLE, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state:
  - srg_clr_out pulses 1 cycle; bit counter = 0; byte_cnt_out = 0; sda_out = 1.
  - Next state is ADDR (repeated START is handled the same way).
- STOP from any state: go to IDLE, sda_out = 1, busy_out = 0.
- ADDR:
  - On each scl_rise: srg_next_out pulses and the bit counter increments.
  - On the 8th rise: rnw_out is captured from SDA.
  - At the next scl_fall, check srg_addrok_in:
    - 1: go to ADDR_ACK with sda_out = 0, busy_out = 1.
    - 0: go to WAIT_STOP with sda_out = 1.
- ADDR_ACK, on scl_fall:
  - rnw = 0: release SDA and go to WDATA.
  - rnw = 1: pulse rd_req_out, go to RDATA, sda_out = srg_bit_in.
- WDATA:
  - Shift on scl_rise as in ADDR.
  - At the scl_fall after the 8th bit: pulse wr_byte_out, increment byte_cnt_out (saturating), set sda_out = 0, go to WDATA_ACK.
- WDATA_ACK, on scl_fall: release SDA, clear the bit counter, go to WDATA.
- RDATA:
  - sda_out follows srg_bit_in.
  - On each scl_fall: srg_next_out pulses and the bit counter increments.
  - After the 8th fall: sda_out = 1, go to RDATA_ACK.
- RDATA_ACK, on scl_rise, sample SDA:
  - 0 (master ACK): increment byte_cnt_out and pulse rd_req_out at the following scl_fall, then go to RDATA.
  - 1 (NACK): go to WAIT_STOP and clear busy_out.
- WAIT_STOP: ignore everything except START/STOP.
- Reset values: state IDLE, sda_out = 1, all strobes 0, rnw_out = 0, byte_cnt_out = 0, busy_out = 0, synchronizers all 1.
- Mid-transfer rst_n assertion releases SDA immediately (asynchronous).
- SCL edges in IDLE are ignored.
- At most one of srg_clr_out and srg_next_out is high in any cycle.

Test Plan:
- Write, address match: START, addr 0x2A+W, bytes 0x5A, 0xC3, STOP -> srg_clr_out ×1, srg_next_out ×24, ACK (sda_out = 0) on the 9th clock of all 3 bytes, wr_byte_out ×2, byte_cnt_out = 2, busy_out falls at STOP.
- Address mismatch: START, addr 0x11+W (srg_addrok_in = 0) -> sda_out stays 1 through the 9th clock, no wr_byte_out, state WAIT_STOP until STOP.
- Read: START, 0x2A+R, upstream loads 0xA5 on rd_req_out; master ACKs, then NACKs the second byte -> SDA carries 1010_0101 MSB-first on SCL-high phases, rd_req_out ×2, byte_cnt_out = 1, SDA released after NACK.
- Repeated START: START, 0x2A+W, one byte, START, 0x2A+R -> second srg_clr_out pulse, byte_cnt_out resets to 0, rnw_out = 1.
- STOP mid-byte: STOP after 3 data bits -> IDLE, sda_out = 1, no wr_byte_out.
- Reset during ACK drive: assert rst_n while sda_out = 0 -> sda_out = 1 within the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/i2c_ctrl.sv
// I2C slave sequencer for i2c_srg: sync SCL/SDA, detect START/STOP, frame bits/bytes, drive ACK/read data.
// Latency: SYNC_STAGES+1 clk from a raw bus edge to its registered strobe/SDA response.
// Backpressure: none; the bus master sets the pace, and each SCL phase must last at least 4 clk.
module i2c_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int BYTE_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_out,
    output logic                  srg_clr_out,
    output logic                  srg_next_out,
    output logic                  srg_bit_out,
    input  logic                  srg_bit_in,
    input  logic                  srg_addrok_in,
    output logic                  rnw_out,
    output logic                  wr_byte_out,
    output logic                  rd_req_out,
    output logic [BYTE_CNT_W-1:0] byte_cnt_out,
    output logic                  busy_out
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    localparam logic [BYTE_CNT_W-1:0] BYTE_ONE = 1;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;

    state_t                 state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                   sda_q, sda_d;
    logic                   clr_q, clr_d;
    logic                   next_q, next_d;
    logic                   wr_byte_q, wr_byte_d;
    logic                   rd_req_q, rd_req_d;
    logic                   rnw_q, rnw_d;
    logic                   busy_q, busy_d;
    logic                   mack_q, mack_d;

    // Shift the raw lines into the synchronizer chains.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end

    // Synchronizers and the one-cycle-delayed copies used for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign sda_rise = sda_s & ~sda_prev_q;
    assign sda_fall = ~sda_s & sda_prev_q;
    // SCL must be high in both samples so a simultaneous SCL edge is never mistaken for START/STOP.
    assign start_det = sda_fall & scl_s & scl_prev_q;
    assign stop_det  = sda_rise & scl_s & scl_prev_q;

    // Next-state and next-output computation; START/STOP override any data-phase action.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        sda_d      = sda_q;
        clr_d      = 1'b0;
        next_d     = 1'b0;
        wr_byte_d  = 1'b0;
        rd_req_d   = 1'b0;
        rnw_d      = rnw_q;
        busy_d     = busy_q;
        mack_d     = mack_q;

        if (start_det) begin
            clr_d      = 1'b1;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = '0;
            sda_d      = 1'b1;
            mack_d     = 1'b0;
            state_d    = ADDR;
        end else if (stop_det) begin
            sda_d   = 1'b1;
            busy_d  = 1'b0;
            mack_d  = 1'b0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, WAIT_STOP: begin
                end
                ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        next_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) rnw_d = sda_s;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (srg_addrok_in) begin
                            sda_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = ADDR_ACK;
                        end else begin
                            sda_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rnw_q) begin
                            rd_req_d = 1'b1;
                            sda_d    = srg_bit_in;
                            state_d  = RDATA;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        next_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        wr_byte_d = 1'b1;
                        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BYTE_ONE;
                        sda_d     = 1'b0;
                        state_d   = WDATA_ACK;
                    end
                end
                WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_d     = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = WDATA;
                    end
                end
                RDATA: begin
                    // Track the shift register MSB; it changes after each load or shift.
                    sda_d = srg_bit_in;
                    if (scl_fall) begin
                        next_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            sda_d   = 1'b1;
                            mack_d  = 1'b0;
                            state_d = RDATA_ACK;
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            mack_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall && mack_q) begin
                        if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + BYTE_ONE;
                        rd_req_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        mack_d    = 1'b0;
                        sda_d     = srg_bit_in;
                        state_d   = RDATA;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and registered outputs; reset releases SDA asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= '0;
            sda_q      <= 1'b1;
            clr_q      <= 1'b0;
            next_q     <= 1'b0;
            wr_byte_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            rnw_q      <= 1'b0;
            busy_q     <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            sda_q      <= sda_d;
            clr_q      <= clr_d;
            next_q     <= next_d;
            wr_byte_q  <= wr_byte_d;
            rd_req_q   <= rd_req_d;
            rnw_q      <= rnw_d;
            busy_q     <= busy_d;
            mack_q     <= mack_d;
        end
    end

    assign sda_out      = sda_q;
    assign srg_clr_out  = clr_q;
    assign srg_next_out = next_q;
    assign srg_bit_out  = sda_s;
    assign rnw_out      = rnw_q;
    assign wr_byte_out  = wr_byte_q;
    assign rd_req_out   = rd_req_q;
    assign byte_cnt_out = byte_cnt_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_i2c_ctrl.sv
// Directed bench for i2c_ctrl: bus master tasks, a small i2c_srg model and strobe counters.
// Latency: checks are taken on falling clk edges, well after registered outputs settle.
// Backpressure: none; the bench master paces SCL with 10-clk phases.
module tb_i2c_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in;
    logic       sda_out, srg_clr_out, srg_next_out, srg_bit_out;
    logic       srg_bit_in, srg_addrok_in;
    logic       rnw_out, wr_byte_out, rd_req_out, busy_out;
    logic [3:0] byte_cnt_out;

    logic [7:0] sr;
    logic [7:0] wr_last, wr_prev;
    int         n_clr = 0, n_next = 0, n_wr = 0, n_rd = 0, n_both = 0;
    int         checks = 0, errors = 0;

    i2c_ctrl #(.SYNC_STAGES(2), .BYTE_CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scl_in       (scl_in),
        .sda_in       (sda_in),
        .sda_out      (sda_out),
        .srg_clr_out  (srg_clr_out),
        .srg_next_out (srg_next_out),
        .srg_bit_out  (srg_bit_out),
        .srg_bit_in   (srg_bit_in),
        .srg_addrok_in(srg_addrok_in),
        .rnw_out      (rnw_out),
        .wr_byte_out  (wr_byte_out),
        .rd_req_out   (rd_req_out),
        .byte_cnt_out (byte_cnt_out),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    // Open-drain bus: either side may pull SDA low.
    assign scl_in = scl_m;
    assign sda_in = sda_m & sda_out;

    // Shift register model; upstream always loads 0xA5 on a read request.
    always @(posedge clk) begin
        if (srg_clr_out)       sr <= 8'h00;
        else if (srg_next_out) sr <= {sr[6:0], srg_bit_out};
        else if (rd_req_out)   sr <= 8'hA5;
    end
    assign srg_bit_in    = sr[7];
    assign srg_addrok_in = (sr[7:1] == 7'h2A);

    // Strobe counters and captured write data.
    always @(posedge clk) begin
        if (srg_clr_out)  n_clr  <= n_clr + 1;
        if (srg_next_out) n_next <= n_next + 1;
        if (rd_req_out)   n_rd   <= n_rd + 1;
        if (srg_clr_out && srg_next_out) n_both <= n_both + 1;
        if (wr_byte_out) begin
            n_wr    <= n_wr + 1;
            wr_prev <= wr_last;
            wr_last <= sr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock starting and ending with SCL low; returns SDA sampled mid-high.
    task automatic bit_cycle(input logic b, output logic got);
        cyc(2); sda_m = b;
        cyc(8); scl_m = 1'b1;
        cyc(5); got = sda_in;
        cyc(5); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], g);
        bit_cycle(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, g);
            d[i] = g;
        end
        bit_cycle(mack, g);
    endtask

    task automatic do_start;
        cyc(2); sda_m = 1'b1;
        cyc(4); scl_m = 1'b1;
        cyc(8); sda_m = 1'b0;
        cyc(8); scl_m = 1'b0;
    endtask

    task automatic do_stop;
        cyc(2); sda_m = 1'b0;
        cyc(8); scl_m = 1'b1;
        cyc(8); sda_m = 1'b1;
        cyc(8);
    endtask

    initial begin
        logic       ack, g;
        logic [7:0] d;
        int         b_clr, b_next, b_wr, b_rd;

        // Reset state
        cyc(3);
        check("rst_sda", sda_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_bytecnt", byte_cnt_out, 0);
        check("rst_strobes", {srg_clr_out, srg_next_out, wr_byte_out, rd_req_out, rnw_out}, 0);
        rst_n = 1'b1;
        cyc(5);

        // Write with address match: 0x2A+W, 0x5A, 0xC3
        b_clr = n_clr; b_next = n_next; b_wr = n_wr;
        do_start;
        send_byte(8'h54, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_rnw", rnw_out, 0);
        check("wr_busy", busy_out, 1);
        send_byte(8'h5A, ack);
        check("wr_b0_ack", ack, 0);
        send_byte(8'hC3, ack);
        check("wr_b1_ack", ack, 0);
        check("wr_clr_cnt", n_clr - b_clr, 1);
        check("wr_next_cnt", n_next - b_next, 24);
        check("wr_byte_cnt_pulses", n_wr - b_wr, 2);
        check("wr_data0", wr_prev, 8'h5A);
        check("wr_data1", wr_last, 8'hC3);
        check("wr_bytecnt", byte_cnt_out, 2);
        check("wr_busy_prestop", busy_out, 1);
        do_stop;
        check("wr_busy_stop", busy_out, 0);
        check("wr_sda_stop", sda_out, 1);

        // Address mismatch: 0x11+W, then a data byte that must be ignored
        b_next = n_next; b_wr = n_wr;
        do_start;
        send_byte(8'h22, ack);
        check("mm_addr_nack", ack, 1);
        send_byte(8'h00, ack);
        check("mm_data_nack", ack, 1);
        check("mm_no_wr", n_wr - b_wr, 0);
        check("mm_next_cnt", n_next - b_next, 8);
        check("mm_busy", busy_out, 0);
        do_stop;

        // Read: 0x2A+R, master ACKs first byte, NACKs second
        b_rd = n_rd;
        do_start;
        send_byte(8'h55, ack);
        check("rd_addr_ack", ack, 0);
        check("rd_rnw", rnw_out, 1);
        read_byte(1'b0, d);
        check("rd_data0", d, 8'hA5);
        read_byte(1'b1, d);
        check("rd_data1", d, 8'hA5);
        check("rd_req_cnt", n_rd - b_rd, 2);
        check("rd_bytecnt", byte_cnt_out, 1);
        cyc(4);
        check("rd_sda_rel", sda_out, 1);
        check("rd_busy_nack", busy_out, 0);
        do_stop;

        // Repeated START: write one byte then restart as read
        b_clr = n_clr;
        do_start;
        send_byte(8'h54, ack);
        send_byte(8'h33, ack);
        check("rs_b0_ack", ack, 0);
        check("rs_bytecnt_pre", byte_cnt_out, 1);
        do_start;
        check("rs_clr_cnt", n_clr - b_clr, 2);
        check("rs_bytecnt_post", byte_cnt_out, 0);
        send_byte(8'h55, ack);
        check("rs_addr_ack", ack, 0);
        check("rs_rnw", rnw_out, 1);
        read_byte(1'b1, d);
        check("rs_data", d, 8'hA5);
        do_stop;

        // STOP after three data bits
        do_start;
        send_byte(8'h54, ack);
        b_wr = n_wr;
        bit_cycle(1'b1, g);
        bit_cycle(1'b0, g);
        bit_cycle(1'b1, g);
        do_stop;
        check("sm_no_wr", n_wr - b_wr, 0);
        check("sm_busy", busy_out, 0);
        check("sm_sda", sda_out, 1);
        check("sm_bytecnt", byte_cnt_out, 0);

        // SCL toggles while idle must not shift
        b_next = n_next;
        cyc(2); scl_m = 1'b0;
        cyc(10); scl_m = 1'b1;
        cyc(10);
        check("idle_no_next", n_next - b_next, 0);

        // Asynchronous reset while the address ACK is driven
        do_start;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i] | 1'b0 ? 1'b0 : 1'b0, g);
        cyc(1);
        cyc(1);
        check("ar_pre_busy", busy_out, 0);
        do_stop;
        do_start;
        d = 8'h54;
        for (int i = 7; i >= 0; i--) bit_cycle(d[i], g);
        cyc(6);
        check("ar_ack_drive", sda_out, 0);
        rst_n = 1'b0;
        #1;
        check("ar_sda", sda_out, 1);
        check("ar_busy", busy_out, 0);
        check("ar_bytecnt", byte_cnt_out, 0);
        check("ar_strobes", {srg_clr_out, srg_next_out, wr_byte_out, rd_req_out, rnw_out}, 0);
        cyc(2);
        rst_n = 1'b1;
        sda_m = 1'b1;
        scl_m = 1'b1;
        cyc(10);

        check("no_clr_next_overlap", n_both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
